// File: rtl/g_re_pkg.sv
// Shared widths and FSM state type for the green-channel zone accumulator.
package g_re_pkg;

  localparam int ZONE_AW   = 7;   // zone index width, matches G_re ADDR_WIDTH
  localparam int ACC_W     = 60;  // accumulator width, matches G_re DATA_WIDTH
  localparam int PIX_W     = 8;   // green sample width
  localparam int NUM_ZONES = 128;

  typedef enum logic [2:0] {
    ST_CLEAR = 3'd0,
    ST_IDLE  = 3'd1,
    ST_ACCUM = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DUMP  = 3'd4
  } g_re_state_e;

endpackage

// File: rtl/G_re.sv
// 128x60 simple dual-port distributed RAM: synchronous write, asynchronous read.
// Contents are not reset; the controller clears them by walking every address.
module G_re #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 60
) (
  input  logic                  wr_clk,
  input  logic                  rd_clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  // Read side has no output register, so rd_clk and rst have nothing to drive.
  logic unused_ports;
  assign unused_ports = rd_clk ^ rst;

  // Write port.
  always_ff @(posedge wr_clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Combinational read port.
  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/g_re_zone_accum_ctrl.sv
// Per-zone green accumulator controller: clears the G_re RAM, accumulates
// samples into 128 bins during a frame, then drains and clears every bin.
//
// Handshakes: a pixel moves when pix_valid & pix_ready on a rising clk edge;
// a drain beat moves when out_valid & out_ready. out_valid never waits on
// out_ready, and out_zone/out_sum hold while a beat is stalled. pix_ready
// depends on state only.
module g_re_zone_accum_ctrl
  import g_re_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic               frame_end,
  input  logic               pix_valid,
  input  logic [ZONE_AW-1:0] pix_zone,
  input  logic [PIX_W-1:0]   pix_g,
  output logic               pix_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ZONE_AW-1:0] out_zone,
  output logic [ACC_W-1:0]   out_sum,
  output logic               busy,
  output logic               frame_err,
  output g_re_state_e        dbg_state_o
);

  localparam logic [ZONE_AW-1:0] LAST_ZONE = ZONE_AW'(NUM_ZONES - 1);

  g_re_state_e        state_q, state_d;
  logic [ZONE_AW-1:0] clr_cnt_q, clr_cnt_d;
  logic [ZONE_AW-1:0] dump_cnt_q, dump_cnt_d;
  logic               s1_valid_q, s1_valid_d;
  logic [ZONE_AW-1:0] s1_zone_q, s1_zone_d;
  logic [PIX_W-1:0]   s1_g_q, s1_g_d;
  logic               frame_err_q, frame_err_d;

  logic               ram_wr_en;
  logic [ZONE_AW-1:0] ram_wr_addr;
  logic [ACC_W-1:0]   ram_wr_data;
  logic [ZONE_AW-1:0] ram_rd_addr;
  logic [ACC_W-1:0]   ram_rd_data;

  // Next-state, output and RAM port muxing; stage 2 of the read-modify-write
  // is the default RAM usage and CLEAR/DUMP override it.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    dump_cnt_d  = dump_cnt_q;
    s1_valid_d  = 1'b0;
    s1_zone_d   = s1_zone_q;
    s1_g_d      = s1_g_q;
    frame_err_d = frame_err_q;
    pix_ready   = 1'b0;
    out_valid   = 1'b0;
    out_zone    = '0;
    out_sum     = '0;
    busy        = 1'b0;
    ram_wr_en   = 1'b0;
    ram_wr_addr = s1_zone_q;
    ram_wr_data = ram_rd_data + {{(ACC_W-PIX_W){1'b0}}, s1_g_q};
    ram_rd_addr = s1_zone_q;

    unique case (state_q)
      ST_CLEAR: begin
        busy        = 1'b1;
        ram_wr_en   = 1'b1;
        ram_wr_addr = clr_cnt_q;
        ram_wr_data = '0;
        clr_cnt_d   = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_ZONE) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (frame_start) begin
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        pix_ready  = 1'b1;
        ram_wr_en  = s1_valid_q;
        s1_valid_d = pix_valid;
        if (pix_valid) begin
          s1_zone_d = pix_zone;
          s1_g_d    = pix_g;
        end
        if (frame_start) begin
          frame_err_d = 1'b1;
        end
        if (frame_end) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // Commit the last stage-1 sample before the drain starts reading.
        busy       = 1'b1;
        ram_wr_en  = s1_valid_q;
        dump_cnt_d = '0;
        state_d    = ST_DUMP;
        if (frame_start || frame_end) begin
          frame_err_d = 1'b1;
        end
      end
      ST_DUMP: begin
        busy        = 1'b1;
        out_valid   = 1'b1;
        out_zone    = dump_cnt_q;
        out_sum     = ram_rd_data;
        ram_rd_addr = dump_cnt_q;
        if (out_ready) begin
          // Clear-on-read leaves the RAM zeroed for the next frame.
          ram_wr_en   = 1'b1;
          ram_wr_addr = dump_cnt_q;
          ram_wr_data = '0;
          dump_cnt_d  = dump_cnt_q + 1'b1;
          if (dump_cnt_q == LAST_ZONE) begin
            state_d = ST_IDLE;
          end
        end
        if (frame_start || frame_end) begin
          frame_err_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  // State, counters, stage-1 pipeline and sticky error register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_CLEAR;
      clr_cnt_q   <= '0;
      dump_cnt_q  <= '0;
      s1_valid_q  <= 1'b0;
      s1_zone_q   <= '0;
      s1_g_q      <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      dump_cnt_q  <= dump_cnt_d;
      s1_valid_q  <= s1_valid_d;
      s1_zone_q   <= s1_zone_d;
      s1_g_q      <= s1_g_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign frame_err   = frame_err_q;
  assign dbg_state_o = state_q;

  G_re #(
    .ADDR_WIDTH (ZONE_AW),
    .DATA_WIDTH (ACC_W)
  ) u_g_re (
    .wr_clk  (clk),
    .rd_clk  (clk),
    .rst     (rst),
    .wr_en   (ram_wr_en),
    .wr_addr (ram_wr_addr),
    .wr_data (ram_wr_data),
    .rd_addr (ram_rd_addr),
    .rd_data (ram_rd_data)
  );

endmodule

// File: doc/g_re_zone_accum_ctrl.md
# g_re_zone_accum_ctrl

Controller that sequences the 128×60 green-channel distributed SDP RAM (`G_re`) as a per-zone accumulator for the backlight LED path. It clears the RAM after reset and sums 8-bit green samples into 128 zone bins during a frame. At frame end it drains all bins in zone order to the LED driver over a valid/ready stream, clearing each bin as it is read. It sits between the pixel/zone mapper and the LED brightness calculator.

## Interface
Parameters:
- `ZONE_AW`, 7, zone index width. Fixed to match `G_re` ADDR_WIDTH; 128 bins.
- `ACC_W`, 60, accumulator width. Fixed to match `G_re` DATA_WIDTH.
- `PIX_W`, 8, green sample width.

Ports:
- `clk`  in  1  single clock; drives both RAM clocks.
- `rst`  in  1  synchronous, active-high reset.
- `frame_start`  in  1  one-cycle pulse; opens an accumulation frame.
- `frame_end`  in  1  one-cycle pulse; closes the frame.
- `pix_valid`  in  1  sample strobe.
- `pix_zone`  in  `ZONE_AW`  destination bin.
- `pix_g`  in  `PIX_W`  green value.
- `pix_ready`  out  1  high only in ACCUM; samples are accepted when `pix_valid & pix_ready`.
- `out_valid`  out  1  drain beat valid.
- `out_ready`  in  1  downstream accept.
- `out_zone`  out  `ZONE_AW`  bin index of the current beat.
- `out_sum`  out  `ACC_W`  bin sum; 0 when `out_valid` is 0.
- `busy`  out  1  high in CLEAR, FLUSH and DUMP.
- `frame_err`  out  1  sticky protocol-error flag; cleared only by `rst`.

## Operation
- States: CLEAR, IDLE, ACCUM, FLUSH, DUMP. Reset state is CLEAR.
- CLEAR:
  - Counter walks 0..127 and writes 0 to each address, one per cycle.
  - Exits to IDLE after the write to address 127.
- IDLE:
  - `frame_start` goes to ACCUM.
  - A `frame_end` in the same cycle is ignored.
  - `pix_valid` is dropped silently.
- ACCUM, two-stage read-modify-write:
  - Stage 1 registers `{valid, zone, g}`.
  - Stage 2 drives `rd_addr = s1_zone`. The RAM read is combinational (no output register).
  - Stage 2 drives `wr_data = rd_data + zero-extend(s1_g)` with `wr_en = s1_valid` at the same edge.
  - Sums wrap modulo 2^60. No saturation.
  - Back-to-back samples to the same zone need no forwarding: the write commits before the next read.
- ACCUM on `frame_end`:
  - A sample presented in the same cycle is accepted.
  - Then go to FLUSH.
  - `frame_start` while in ACCUM sets `frame_err` and is otherwise ignored.
- FLUSH:
  - Lasts one cycle. The final stage-1 sample is committed.
  - Then go to DUMP with the drain counter at 0.
- DUMP:
  - `out_valid=1`, `out_zone` = counter, `rd_addr` = counter, `out_sum = rd_data`.
  - On `out_valid & out_ready`: write 0 to the counter address and increment the counter.
  - After the beat for zone 127, go to IDLE. The RAM is left all-zero.
  - `frame_start` or `frame_end` during FLUSH or DUMP sets `frame_err` and is ignored.
  - `pix_valid` is dropped.
- RAM port usage per state:
  - Write port: CLEAR counter, stage 2, or DUMP counter. Only one source is ever active.
  - Read port: stage-1 zone in ACCUM/FLUSH; drain counter in DUMP.

## Timing
- Reset values (the state register resets to CLEAR):
  - `out_valid=0`, `out_zone=0`, `out_sum=0`.
  - `pix_ready=0`, `busy=1`, `frame_err=0`.
  - All counters 0, stage-1 valid 0.
- `rst` asserted in any state:
  - Next cycle is CLEAR.
  - Any in-flight sample or drain is abandoned.
  - CLEAR takes 128 cycles, then IDLE.
- Sample accepted in cycle t is written at the end of t+1.
- `frame_end` at cycle t: FLUSH is t+1, and the first `out_valid` (zone 0) is t+2.
- Drain takes 128 handshakes. With `out_ready` held high this is 128 consecutive cycles.
- While `out_valid & !out_ready`, `out_zone` and `out_sum` hold stable.
- `pix_ready` is combinational from state. It never depends on `pix_valid`.

## Structure
- Shared package `g_re_pkg` holds:
  - `ZONE_AW`, `ACC_W`, `PIX_W`, `NUM_ZONES=128`.
  - The state enum type.
- One sub-module: a `G_re` instance.
  - `wr_clk` and `rd_clk` both tie to `clk`; its `rst` ties to `rst`.
  - All RAM address and data muxing lives in this block.
- Expected size: about 200 lines of RTL.

## Test plan
- Reset → `busy=1` for 128 cycles, then IDLE. An empty frame (start, end) drains 128 beats, zones 0..127, all sums 0.
- Frame with zone 5, g=10 on 3 back-to-back cycles, plus zone 127, g=255 → drain gives zone 5 = 30, zone 127 = 255, all other zones 0.
- `out_ready` pattern 1,0,0,1 repeating during drain → `out_zone`/`out_sum` stable across stalls. Exactly 128 beats, no duplicates or skips.
- Last sample (zone 0, g=7) in the same cycle as `frame_end` → zone 0 drains as 7. A second identical frame also drains 7, proving clear-on-read.
- `frame_start` pulsed during DUMP and `pix_valid` asserted in IDLE → `frame_err=1`, drain unaffected, dropped samples absent from the next frame.
- `rst` asserted mid-ACCUM after 50 samples → `out_valid=0`, `busy=1` for 128 cycles. The next empty frame drains all zeros.
